// File: rtl/logic_op_scheduler.sv
// Two-requester round-robin scheduler feeding a single-cycle bitwise/shift unit.
// One operation in flight at a time; results are held until the consumer takes them.
module logic_op_scheduler #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t           state;
   logic             last_grant;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             id_q;
   logic             grant0;
   logic             grant1;
   logic [WIDTH-1:0] result;

   // On a tie the requester that did not win last time is served; reset gates grants off.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE && !rst) begin
         grant0 = req0_valid && (!req1_valid || last_grant);
         grant1 = req1_valid && (!req0_valid || !last_grant);
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      result = '0;
      case (op_q)
         3'd0:    result = ~a_q;
         3'd1:    result = ~b_q;
         3'd2:    result = a_q | b_q;
         3'd3:    result = a_q & b_q;
         3'd4:    result = a_q ^ b_q;
         3'd5:    result = ~(a_q ^ b_q);
         3'd6:    result = {1'b0, a_q[WIDTH-1:1]};
         default: result = {a_q[WIDTH-2:0], 1'b0};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  op_q       <= grant1 ? req1_op : req0_op;
                  a_q        <= grant1 ? req1_a  : req0_a;
                  b_q        <= grant1 ? req1_b  : req0_b;
                  id_q       <= grant1;
                  last_grant <= grant1;
                  busy       <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_data  <= result;
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Self-checking bench for logic_op_scheduler: directed scenarios plus a randomized
// run scored against a cycle-level reference of the arbitration and latency rules.
module tb_logic_op_scheduler;

   localparam int WIDTH = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req0_valid = 1'b0;
   logic             req0_ready;
   logic [2:0]       req0_op = '0;
   logic [WIDTH-1:0] req0_a = '0;
   logic [WIDTH-1:0] req0_b = '0;
   logic             req1_valid = 1'b0;
   logic             req1_ready;
   logic [2:0]       req1_op = '0;
   logic [WIDTH-1:0] req1_a = '0;
   logic [WIDTH-1:0] req1_b = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             busy;

   int checks = 0;
   int failures = 0;

   logic_op_scheduler #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference result computed with plain integer arithmetic on 6-bit values.
   function automatic logic [5:0] model_op(input int op, input int a, input int b);
      int r;
      case (op)
         0:       r = 63 - a;
         1:       r = 63 - b;
         2:       r = a | b;
         3:       r = a & b;
         4:       r = a ^ b;
         5:       r = 63 - (a ^ b);
         6:       r = a / 2;
         default: r = (a * 2) % 64;
      endcase
      return r[5:0];
   endfunction

   task automatic do_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      rst = 1'b1;
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      req0_valid = 1'b1; req0_op = 3'd5; req0_a = 6'h2A; req0_b = 6'h11;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = 3'd2; req1_a = 6'h01; req1_b = 6'h02;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_precond rsp_valid=%b busy=%b required 1 1", rsp_valid, busy);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, busy, req0_ready, req1_ready} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_async rsp_valid=%b rsp_id=%b rsp_data=%h busy=%b rdy0=%b rdy1=%b required all 0",
                  rsp_valid, rsp_id, rsp_data, busy, req0_ready, req1_ready);
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_release busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
      end
      checks++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_first_idle rdy0=%b rdy1=%b required 0 1", req0_ready, req1_ready);
      end
      req1_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_op();
      do_reset();
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 3'd4; req0_a = 6'b101100; req0_b = 6'b011010;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_ready rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_exec busy=%b rsp_valid=%b required 1 0", busy, rsp_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 6'b110110 || rsp_id !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_resp valid=%b data=%b id=%b required 1 110110 0", rsp_valid, rsp_data, rsp_id);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_done busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [5:0] exp_data;
      do_reset();
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 3'd2; req0_a = 6'h0F; req0_b = 6'h30;
      req1_valid = 1'b1; req1_op = 3'd6; req1_a = 6'b100001; req1_b = 6'($urandom);
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_data = (k % 2 == 1) ? 6'b010000 : 6'h3F;
         checks++;
         if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
            failures++;
            $display("[TB] FAIL rr_grant_%0d rdy0=%b rdy1=%b required winner %0d", k, req0_ready, req1_ready, k % 2);
         end
         @(posedge clk); #1;
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_id !== 1'(k % 2)
             || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rr_resp_%0d valid=%b data=%h id=%b rdy=%b%b required 1 %h %0d 00",
                     k, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready, exp_data, k % 2);
         end
         @(posedge clk); #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      req0_valid = 1'b1; req0_op = 3'd7; req0_a = 6'b110011; req0_b = 6'($urandom);
      #1;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = 3'd3; req1_a = 6'($urandom); req1_b = 6'($urandom);
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 6'b100110 || rsp_id !== 1'b0
             || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_hold_%0d valid=%b data=%b id=%b rdy=%b%b required 1 100110 0 00",
                     c, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready);
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_release rsp_valid=%b rdy1=%b required 0 1", rsp_valid, req1_ready);
      end
      req1_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op();
      logic [5:0] a, b;
      do_reset();
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 3'd0; req0_a = 6'h00; req0_b = 6'h00;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_busy busy=%b required 0", busy);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_norsp_%0d rsp_valid=%b required 0", c, rsp_valid);
         end
      end
      a = 6'($urandom); b = 6'($urandom);
      req1_valid = 1'b1; req1_op = 3'd3; req1_a = a; req1_b = b;
      #1;
      checks++;
      if (req1_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midrst_next_ready rdy1=%b required 1", req1_ready);
      end
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== model_op(3, a, b) || rsp_id !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midrst_next_resp valid=%b data=%h id=%b required 1 %h 1",
                  rsp_valid, rsp_data, rsp_id, model_op(3, a, b));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_opcode_sweep();
      logic [5:0] exp_tab [8];
      exp_tab = '{6'b010101, 6'b001100, 6'b111011, 6'b100010,
                  6'b011001, 6'b100110, 6'b010101, 6'b010100};
      do_reset();
      rsp_ready = 1'b1;
      for (int op = 0; op < 8; op++) begin
         req0_valid = 1'b1; req0_op = 3'(op); req0_a = 6'b101010; req0_b = 6'b110011;
         @(posedge clk); #1;
         req0_valid = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_tab[op]) begin
            failures++;
            $display("[TB] FAIL sweep_op%0d valid=%b data=%b required 1 %b", op, rsp_valid, rsp_data, exp_tab[op]);
         end
         @(posedge clk); #1;
      end
   endtask

   // Randomized traffic: requesters hold valid until served; consumer throttles at random.
   task automatic test_random();
      logic       pend [2];
      logic [2:0] pop  [2];
      logic [5:0] pa   [2];
      logic [5:0] pb   [2];
      logic       last_w = 1'b1;
      logic       outstanding = 1'b0;
      int         acc_cyc = 0;
      logic [5:0] exp_data = '0;
      logic       exp_id = 1'b0;
      int         w;
      logic       exp_rv;
      pend[0] = 1'b0; pend[1] = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && ($urandom % 3 == 0)) begin
               pend[i] = 1'b1;
               pop[i] = 3'($urandom);
               pa[i] = 6'($urandom);
               pb[i] = 6'($urandom);
            end
         end
         req0_valid = pend[0]; req0_op = pop[0]; req0_a = pa[0]; req0_b = pb[0];
         req1_valid = pend[1]; req1_op = pop[1]; req1_a = pa[1]; req1_b = pb[1];
         rsp_ready = 1'($urandom);
         #1;
         w = -1;
         if (!outstanding && (pend[0] || pend[1]))
            w = (pend[0] && pend[1]) ? (last_w ? 0 : 1) : (pend[0] ? 0 : 1);
         checks++;
         if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin
            failures++;
            $display("[TB] FAIL rand_ready cyc=%0d rdy0=%b rdy1=%b required winner %0d", cyc, req0_ready, req1_ready, w);
         end
         exp_rv = outstanding && (cyc >= acc_cyc + 2);
         checks++;
         if (rsp_valid !== exp_rv) begin
            failures++;
            $display("[TB] FAIL rand_valid cyc=%0d rsp_valid=%b required %b", cyc, rsp_valid, exp_rv);
         end
         if (exp_rv) begin
            checks++;
            if (rsp_data !== exp_data || rsp_id !== exp_id) begin
               failures++;
               $display("[TB] FAIL rand_data cyc=%0d data=%h id=%b required %h %b", cyc, rsp_data, rsp_id, exp_data, exp_id);
            end
         end
         if (w >= 0) begin
            outstanding = 1'b1;
            acc_cyc = cyc;
            exp_data = model_op(int'(pop[w]), int'(pa[w]), int'(pb[w]));
            exp_id = 1'(w);
            last_w = 1'(w);
            pend[w] = 1'b0;
         end else if (exp_rv && rsp_ready) begin
            outstanding = 1'b0;
         end
         @(posedge clk); #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_round_robin();
      test_backpressure();
      test_reset_mid_op();
      test_opcode_sweep();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
